// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reorder_buffer_pkg
// Brief   : Shared ROB sizing and entry layout (also used by the RS rob_index)
// Revision: 1.0
// ============================================================================
package reorder_buffer_pkg;

  localparam int ROB_DEPTH  = 32;
  localparam int ROB_IDX_W  = $clog2(ROB_DEPTH);
  localparam int ROB_PREG_W = 6;
  localparam int ROB_NUM_FU = 3;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  has_dst;
    logic [ROB_PREG_W-1:0] rd;
    logic [ROB_PREG_W-1:0] old_rd;
  } rob_entry_t;

  // Freshly dispatched entry: live but not yet completed.
  function automatic rob_entry_t rob_entry_new(input logic                  has_dst,
                                               input logic [ROB_PREG_W-1:0] rd,
                                               input logic [ROB_PREG_W-1:0] old_rd);
    rob_entry_t e;
    e.valid   = 1'b1;
    e.done    = 1'b0;
    e.has_dst = has_dst;
    e.rd      = rd;
    e.old_rd  = old_rd;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module  : reorder_buffer
// Brief   : Circular in-order completion tracker, 2-wide dispatch/retire,
//           NUM_FU completion ports. Optional flush port: define ROB_FLUSH_EN.
// Revision: 1.0
// ============================================================================
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int NUM_FU = ROB_NUM_FU
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef ROB_FLUSH_EN
  input  logic                    flush,
`endif
  input  logic                    disp_valid_1,
  input  logic                    disp_has_dst_1,
  input  logic [ROB_PREG_W-1:0]   disp_rd_1,
  input  logic [ROB_PREG_W-1:0]   disp_old_rd_1,
  input  logic                    disp_valid_2,
  input  logic                    disp_has_dst_2,
  input  logic [ROB_PREG_W-1:0]   disp_rd_2,
  input  logic [ROB_PREG_W-1:0]   disp_old_rd_2,
  output logic [$clog2(DEPTH)-1:0] alloc_idx_1,
  output logic [$clog2(DEPTH)-1:0] alloc_idx_2,
  output logic                    full,
  output logic                    empty,
  input  logic [NUM_FU-1:0]       cmp_valid,
  input  logic [NUM_FU*$clog2(DEPTH)-1:0] cmp_idx,
  output logic                    ret_valid_1,
  output logic [ROB_PREG_W-1:0]   ret_rd_1,
  output logic                    free_valid_1,
  output logic [ROB_PREG_W-1:0]   free_reg_1,
  output logic                    ret_valid_2,
  output logic [ROB_PREG_W-1:0]   ret_rd_2,
  output logic                    free_valid_2,
  output logic [ROB_PREG_W-1:0]   free_reg_2
);

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam int               PREG_W   = ROB_PREG_W;
  localparam logic [IDX_W:0]   FULL_LVL = (IDX_W+1)'(DEPTH - 1);

  rob_entry_t entries_q [DEPTH];
  rob_entry_t entries_d [DEPTH];

  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [IDX_W:0]    count_q, count_d;

  logic              ret_valid_1_q, ret_valid_1_d;
  logic              ret_valid_2_q, ret_valid_2_d;
  logic [PREG_W-1:0] ret_rd_1_q, ret_rd_1_d;
  logic [PREG_W-1:0] ret_rd_2_q, ret_rd_2_d;
  logic              free_valid_1_q, free_valid_1_d;
  logic              free_valid_2_q, free_valid_2_d;
  logic [PREG_W-1:0] free_reg_1_q, free_reg_1_d;
  logic [PREG_W-1:0] free_reg_2_q, free_reg_2_d;

  logic              flush_w;
  logic [IDX_W-1:0]  head_p1_w;
  logic [IDX_W-1:0]  tail_p1_w;
  logic              retire_1_w;
  logic              retire_2_w;
  logic              accept_1_w;
  logic              accept_2_w;
  logic [1:0]        n_ret_w;
  logic [1:0]        n_acc_w;

`ifdef ROB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  assign head_p1_w = head_q + 1'b1;
  assign tail_p1_w = tail_q + 1'b1;

  assign full        = (count_q >= FULL_LVL);
  assign empty       = (count_q == '0);
  assign alloc_idx_1 = tail_q;
  assign alloc_idx_2 = tail_p1_w;

  assign retire_1_w = entries_q[head_q].valid & entries_q[head_q].done;
  assign retire_2_w = retire_1_w & entries_q[head_p1_w].valid & entries_q[head_p1_w].done;

  // A lone slot-2 request is illegal and simply not accepted.
  assign accept_1_w = disp_valid_1 & ~full;
  assign accept_2_w = accept_1_w & disp_valid_2;

  assign n_ret_w = {1'b0, retire_1_w} + {1'b0, retire_2_w};
  assign n_acc_w = {1'b0, accept_1_w} + {1'b0, accept_2_w};

  always_comb begin
    entries_d      = entries_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    ret_valid_1_d  = 1'b0;
    ret_valid_2_d  = 1'b0;
    ret_rd_1_d     = '0;
    ret_rd_2_d     = '0;
    free_valid_1_d = 1'b0;
    free_valid_2_d = 1'b0;
    free_reg_1_d   = '0;
    free_reg_2_d   = '0;

    if (flush_w) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Completions are gated by pre-edge valid, so they never touch a slot
      // being dispatched this cycle; retire clears are applied afterwards.
      for (int k = 0; k < NUM_FU; k++) begin
        if (cmp_valid[k] && entries_q[cmp_idx[k*IDX_W +: IDX_W]].valid) begin
          entries_d[cmp_idx[k*IDX_W +: IDX_W]].done = 1'b1;
        end
      end

      if (retire_1_w) begin
        ret_valid_1_d  = 1'b1;
        ret_rd_1_d     = entries_q[head_q].rd;
        free_valid_1_d = entries_q[head_q].has_dst;
        free_reg_1_d   = entries_q[head_q].has_dst ? entries_q[head_q].old_rd : '0;
        entries_d[head_q] = '0;
      end
      if (retire_2_w) begin
        ret_valid_2_d  = 1'b1;
        ret_rd_2_d     = entries_q[head_p1_w].rd;
        free_valid_2_d = entries_q[head_p1_w].has_dst;
        free_reg_2_d   = entries_q[head_p1_w].has_dst ? entries_q[head_p1_w].old_rd : '0;
        entries_d[head_p1_w] = '0;
      end

      // Not full means at least two free slots, disjoint from retiring ones.
      if (accept_1_w) begin
        entries_d[tail_q] = rob_entry_new(disp_has_dst_1, disp_rd_1, disp_old_rd_1);
      end
      if (accept_2_w) begin
        entries_d[tail_p1_w] = rob_entry_new(disp_has_dst_2, disp_rd_2, disp_old_rd_2);
      end

      head_d  = head_q + IDX_W'(n_ret_w);
      tail_d  = tail_q + IDX_W'(n_acc_w);
      count_d = count_q + (IDX_W+1)'(n_acc_w) - (IDX_W+1)'(n_ret_w);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      ret_valid_1_q  <= 1'b0;
      ret_valid_2_q  <= 1'b0;
      ret_rd_1_q     <= '0;
      ret_rd_2_q     <= '0;
      free_valid_1_q <= 1'b0;
      free_valid_2_q <= 1'b0;
      free_reg_1_q   <= '0;
      free_reg_2_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      ret_valid_1_q  <= ret_valid_1_d;
      ret_valid_2_q  <= ret_valid_2_d;
      ret_rd_1_q     <= ret_rd_1_d;
      ret_rd_2_q     <= ret_rd_2_d;
      free_valid_1_q <= free_valid_1_d;
      free_valid_2_q <= free_valid_2_d;
      free_reg_1_q   <= free_reg_1_d;
      free_reg_2_q   <= free_reg_2_d;
    end
  end

  assign ret_valid_1  = ret_valid_1_q;
  assign ret_valid_2  = ret_valid_2_q;
  assign ret_rd_1     = ret_rd_1_q;
  assign ret_rd_2     = ret_rd_2_q;
  assign free_valid_1 = free_valid_1_q;
  assign free_valid_2 = free_valid_2_q;
  assign free_reg_1   = free_reg_1_q;
  assign free_reg_2   = free_reg_2_q;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_reorder_buffer
// Brief   : Self-checking bench for reorder_buffer against a queue-based model.
//           Flush scenarios are included when ROB_FLUSH_EN is defined.
// Revision: 1.0
// ============================================================================
module tb_reorder_buffer;

  localparam int D  = 32;
  localparam int IW = 5;
  localparam int PW = 6;
  localparam int NF = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          fl;
  logic          dv1, dh1, dv2, dh2;
  logic [PW-1:0] rd1, ord1, rd2, ord2;
  logic [NF-1:0] cv;
  logic [NF*IW-1:0] ci;

  logic [IW-1:0] alloc_idx_1, alloc_idx_2;
  logic          full, empty;
  logic          ret_valid_1, ret_valid_2, free_valid_1, free_valid_2;
  logic [PW-1:0] ret_rd_1, ret_rd_2, free_reg_1, free_reg_2;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk            (clk),
    .reset          (reset),
`ifdef ROB_FLUSH_EN
    .flush          (fl),
`endif
    .disp_valid_1   (dv1),
    .disp_has_dst_1 (dh1),
    .disp_rd_1      (rd1),
    .disp_old_rd_1  (ord1),
    .disp_valid_2   (dv2),
    .disp_has_dst_2 (dh2),
    .disp_rd_2      (rd2),
    .disp_old_rd_2  (ord2),
    .alloc_idx_1    (alloc_idx_1),
    .alloc_idx_2    (alloc_idx_2),
    .full           (full),
    .empty          (empty),
    .cmp_valid      (cv),
    .cmp_idx        (ci),
    .ret_valid_1    (ret_valid_1),
    .ret_rd_1       (ret_rd_1),
    .free_valid_1   (free_valid_1),
    .free_reg_1     (free_reg_1),
    .ret_valid_2    (ret_valid_2),
    .ret_rd_2       (ret_rd_2),
    .free_valid_2   (free_valid_2),
    .free_reg_2     (free_reg_2)
  );

  // Reference: program-order queue of in-flight instructions.
  typedef struct {
    bit          has_dst;
    bit [PW-1:0] rd;
    bit [PW-1:0] old_rd;
    bit          done;
  } ment_t;

  ment_t mq[$];
  int    mhead, mtail;
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    fl = 1'b0; dv1 = 1'b0; dh1 = 1'b0; dv2 = 1'b0; dh2 = 1'b0;
    rd1 = '0; ord1 = '0; rd2 = '0; ord2 = '0; cv = '0; ci = '0;
  endtask

  task automatic set_disp(input bit v1, input bit h1, input int r1, input int o1,
                          input bit v2, input bit h2, input int r2, input int o2);
    dv1 = v1; dh1 = h1; rd1 = PW'(r1); ord1 = PW'(o1);
    dv2 = v2; dh2 = h2; rd2 = PW'(r2); ord2 = PW'(o2);
  endtask

  task automatic set_cmp(input int k, input int idx);
    cv[k] = 1'b1;
    ci[k*IW +: IW] = IW'(idx);
  endtask

  // One clock: advance the model from the current inputs, then compare.
  task automatic tick();
    int    sz, idx, pos;
    bit    r1, r2, e_rv1, e_rv2, e_fv1, e_fv2;
    bit [PW-1:0] e_rd1, e_rd2, e_fr1, e_fr2;
    ment_t e;
    assert (!(dv2 && !dv1)) else $error("dispatch slot 2 without slot 1");
    sz = mq.size();
    r1 = (sz > 0) && mq[0].done;
    r2 = r1 && (sz > 1) && mq[1].done;
    {e_rv1, e_rv2, e_fv1, e_fv2} = '0;
    {e_rd1, e_rd2, e_fr1, e_fr2} = '0;
    if (fl) begin
      mq.delete();
      mhead = 0;
      mtail = 0;
    end else begin
      if (r1) begin e_rv1 = 1; e_rd1 = mq[0].rd; e_fv1 = mq[0].has_dst; e_fr1 = mq[0].old_rd; end
      if (r2) begin e_rv2 = 1; e_rd2 = mq[1].rd; e_fv2 = mq[1].has_dst; e_fr2 = mq[1].old_rd; end
      for (int k = 0; k < NF; k++) begin
        if (cv[k]) begin
          idx = int'(ci[k*IW +: IW]);
          pos = (idx - mhead + D) % D;
          if (pos < sz) begin
            e = mq[pos];
            e.done = 1;
            mq[pos] = e;
          end
        end
      end
      if (r1) begin void'(mq.pop_front()); mhead = (mhead + 1) % D; end
      if (r2) begin void'(mq.pop_front()); mhead = (mhead + 1) % D; end
      if (dv1 && sz < D - 1) begin
        mq.push_back('{has_dst: dh1, rd: rd1, old_rd: ord1, done: 0});
        mtail = (mtail + 1) % D;
        if (dv2) begin
          mq.push_back('{has_dst: dh2, rd: rd2, old_rd: ord2, done: 0});
          mtail = (mtail + 1) % D;
        end
      end
    end
    @(posedge clk);
    #1;
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("full", 32'(full), 32'(mq.size() >= D - 1));
    check("alloc_idx_1", 32'(alloc_idx_1), 32'(mtail));
    check("alloc_idx_2", 32'(alloc_idx_2), 32'((mtail + 1) % D));
    check("ret_valid_1", 32'(ret_valid_1), 32'(e_rv1));
    check("ret_valid_2", 32'(ret_valid_2), 32'(e_rv2));
    check("ret_rd_1", 32'(ret_rd_1), 32'(e_rd1));
    check("ret_rd_2", 32'(ret_rd_2), 32'(e_rd2));
    check("free_valid_1", 32'(free_valid_1), 32'(e_fv1));
    check("free_valid_2", 32'(free_valid_2), 32'(e_fv2));
    if (e_fv1) check("free_reg_1", 32'(free_reg_1), 32'(e_fr1));
    if (e_fv2) check("free_reg_2", 32'(free_reg_2), 32'(e_fr2));
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    check("rst_async_ret_valid_1", 32'(ret_valid_1), 32'd0);
    check("rst_async_free_valid_1", 32'(free_valid_1), 32'd0);
    check("rst_async_empty", 32'(empty), 32'd1);
    mq.delete();
    mhead = 0;
    mtail = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic rand_inputs();
    int pick;
    idle_inputs();
    dv1 = ($urandom_range(3) != 0);
    dv2 = dv1 && ($urandom_range(1) == 1);
    dh1 = ($urandom_range(3) != 0);
    dh2 = ($urandom_range(3) != 0);
    rd1 = PW'($urandom); ord1 = PW'($urandom);
    rd2 = PW'($urandom); ord2 = PW'($urandom);
    for (int k = 0; k < NF; k++) begin
      if ($urandom_range(1) == 1) begin
        if (mq.size() > 0 && $urandom_range(7) != 0)
          pick = (mhead + int'($urandom_range(mq.size() - 1))) % D;
        else
          pick = int'($urandom_range(D - 1));
        set_cmp(k, pick);
      end
    end
`ifdef ROB_FLUSH_EN
    fl = ($urandom_range(39) == 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Reset state
    check("t1_empty", 32'(empty), 32'd1);
    check("t1_full", 32'(full), 32'd0);
    check("t1_alloc_idx_1", 32'(alloc_idx_1), 32'd0);
    check("t1_alloc_idx_2", 32'(alloc_idx_2), 32'd1);
    check("t1_ret_valid_1", 32'(ret_valid_1), 32'd0);
    check("t1_ret_valid_2", 32'(ret_valid_2), 32'd0);

    // Younger completes first; nothing retires until the oldest is done
    set_disp(1, 1, 10, 3, 1, 1, 11, 4);
    tick();
    idle_inputs(); set_cmp(0, 1);
    tick();
    idle_inputs();
    tick();
    check("t2_no_retire", 32'(ret_valid_1), 32'd0);
    set_cmp(1, 0);
    tick();
    idle_inputs();
    tick();
    check("t2_ret_rd_1", 32'(ret_rd_1), 32'd10);
    check("t2_ret_rd_2", 32'(ret_rd_2), 32'd11);
    check("t2_free_reg_1", 32'(free_reg_1), 32'd3);
    check("t2_free_reg_2", 32'(free_reg_2), 32'd4);

    // Fill to the full threshold, then a dropped pair
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_disp(1, 1, 2 * i, 40, 1, 1, 2 * i + 1, 41);
      tick();
      if (i == 14) check("t3_full_after_15", 32'(full), 32'd0);
      if (i == 15) check("t3_full_after_16", 32'(full), 32'd1);
    end
    set_disp(1, 1, 7, 7, 1, 1, 8, 8);
    tick();
    check("t3_dropped_alloc_idx_1", 32'(alloc_idx_1), 32'd0);

    // Walk the pointers to 31, then dispatch a pair across the wrap
    do_reset();
    for (int i = 0; i < 15; i++) begin
      set_disp(1, 1, 1, 2, 1, 1, 3, 4);
      tick();
      idle_inputs(); set_cmp(0, 2 * i); set_cmp(1, 2 * i + 1);
      tick();
      idle_inputs();
      tick();
    end
    set_disp(1, 0, 5, 6, 0, 0, 0, 0);
    tick();
    idle_inputs(); set_cmp(2, 30);
    tick();
    idle_inputs();
    tick();
    check("t4_alloc_idx_1", 32'(alloc_idx_1), 32'd31);
    check("t4_alloc_idx_2", 32'(alloc_idx_2), 32'd0);
    set_disp(1, 1, 40, 41, 1, 1, 42, 43);
    tick();
    idle_inputs(); set_cmp(0, 0); set_cmp(1, 31);
    tick();
    idle_inputs();
    tick();
    check("t4_wrap_ret_rd_1", 32'(ret_rd_1), 32'd40);
    check("t4_wrap_ret_rd_2", 32'(ret_rd_2), 32'd42);

    // Store behind an ALU op: both retire, only the ALU op frees a register
    do_reset();
    set_disp(1, 1, 20, 5, 1, 0, 21, 6);
    tick();
    idle_inputs(); set_cmp(0, 0); set_cmp(2, 1);
    tick();
    idle_inputs();
    tick();
    check("t5_ret_valid_1", 32'(ret_valid_1), 32'd1);
    check("t5_ret_valid_2", 32'(ret_valid_2), 32'd1);
    check("t5_free_valid_1", 32'(free_valid_1), 32'd1);
    check("t5_free_valid_2", 32'(free_valid_2), 32'd0);

`ifdef ROB_FLUSH_EN
    // Flush wins over dispatch, completion and a pending retire
    do_reset();
    set_disp(1, 1, 1, 2, 1, 1, 3, 4);
    tick();
    set_disp(1, 1, 5, 6, 1, 1, 7, 8);
    tick();
    set_disp(1, 1, 9, 10, 0, 0, 0, 0); set_cmp(0, 0); set_cmp(1, 1);
    tick();
    idle_inputs();
    fl = 1'b1;
    set_disp(1, 1, 11, 12, 1, 1, 13, 14);
    set_cmp(0, 2); set_cmp(1, 3); set_cmp(2, 4);
    tick();
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_alloc_idx_1", 32'(alloc_idx_1), 32'd0);
    check("t6_ret_valid_1", 32'(ret_valid_1), 32'd0);
    check("t6_free_valid_1", 32'(free_valid_1), 32'd0);
    idle_inputs();
`endif

    // Randomized traffic with one mid-run reset
    do_reset();
    for (int c = 0; c < 500; c++) begin
      if (c == 250) do_reset();
      rand_inputs();
      tick();
    end
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
